// File: rtl/ct_ciu_piu_bar_req_if.sv
// -----------------------------------------------------------------------------
// ct_ciu_piu_bar_req_if
//   Bundles the PIU barrier handshake and the four bmbif request/grant pairs
//   used by ct_ciu_piu_bar_req.
//   slave  : the barrier request generator (consumes PIU request + grants,
//            drives ready, target requests, shared req_bus, done, timeout).
//   master : the environment (PIU and the bmbif arbiters).
// Signals
//   piu_bar_vld / piu_bar_req_bus / piu_bar_tgt : barrier from PIU
//   piu_bar_rdy                                 : generator can accept
//   piu_bmbif_<t>_req, piu_bmbif_req_bus        : requests to arbiters
//   bmbif_piu_<t>_grant                         : grants from arbiters
//   piu_bar_done / piu_bar_tmo                  : completion pulse, watchdog
// -----------------------------------------------------------------------------
interface ct_ciu_piu_bar_req_if #(
  parameter int BUS_W = 9
);
  logic             piu_bar_vld;
  logic [BUS_W-1:0] piu_bar_req_bus;
  logic [3:0]       piu_bar_tgt;
  logic             piu_bar_rdy;
  logic             piu_bmbif_snb0_req;
  logic             piu_bmbif_snb1_req;
  logic             piu_bmbif_ncq_req;
  logic             piu_bmbif_ctcq_req;
  logic [BUS_W-1:0] piu_bmbif_req_bus;
  logic             bmbif_piu_snb0_grant;
  logic             bmbif_piu_snb1_grant;
  logic             bmbif_piu_ncq_grant;
  logic             bmbif_piu_ctcq_grant;
  logic             piu_bar_done;
  logic             piu_bar_tmo;

  modport slave (
    input  piu_bar_vld, piu_bar_req_bus, piu_bar_tgt,
    input  bmbif_piu_snb0_grant, bmbif_piu_snb1_grant,
    input  bmbif_piu_ncq_grant, bmbif_piu_ctcq_grant,
    output piu_bar_rdy,
    output piu_bmbif_snb0_req, piu_bmbif_snb1_req,
    output piu_bmbif_ncq_req, piu_bmbif_ctcq_req,
    output piu_bmbif_req_bus, piu_bar_done, piu_bar_tmo
  );

  modport master (
    output piu_bar_vld, piu_bar_req_bus, piu_bar_tgt,
    output bmbif_piu_snb0_grant, bmbif_piu_snb1_grant,
    output bmbif_piu_ncq_grant, bmbif_piu_ctcq_grant,
    input  piu_bar_rdy,
    input  piu_bmbif_snb0_req, piu_bmbif_snb1_req,
    input  piu_bmbif_ncq_req, piu_bmbif_ctcq_req,
    input  piu_bmbif_req_bus, piu_bar_done, piu_bar_tmo
  );
endinterface

// File: rtl/ct_ciu_piu_bar_req.sv
// -----------------------------------------------------------------------------
// ct_ciu_piu_bar_req
//   Per-PIU barrier request generator. Accepts one barrier from the PIU,
//   raises a request towards every selected bmbif arbiter (snb0, snb1, ncq,
//   ctcq) with a shared, stable req_bus, drops each request the cycle after
//   its grant, and pulses done once every selected target has granted.
//   A watchdog raises a sticky timeout flag if a barrier stays in the request
//   phase for TMO_CYC cycles; it never aborts the barrier.
// Ports
//   forever_cpuclk : clock, rising edge
//   cpurst         : synchronous reset, active-high
//   bar_if         : ct_ciu_piu_bar_req_if.slave (handshake, requests, grants)
// Parameters
//   BUS_W   : req_bus width
//   TMO_CYC : request-phase cycle count at which the timeout flag asserts
//   CNT_W   : watchdog counter width, 2**CNT_W > TMO_CYC
// -----------------------------------------------------------------------------
module ct_ciu_piu_bar_req #(
  parameter int BUS_W   = 9,
  parameter int TMO_CYC = 1024,
  parameter int CNT_W   = 11
) (
  input  logic                        forever_cpuclk,
  input  logic                        cpurst,
  ct_ciu_piu_bar_req_if.slave         bar_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TMO_CYC);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_pend;
  logic [3:0]       w_pend_nxt;
  logic [BUS_W-1:0] r_bus;
  logic [BUS_W-1:0] w_bus_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tmo;
  logic             w_tmo_nxt;
  logic [3:0]       w_grant;
  logic             w_accept;

  // Grant vector in target-mask order {ctcq, ncq, snb1, snb0}.
  assign w_grant  = {bar_if.bmbif_piu_ctcq_grant, bar_if.bmbif_piu_ncq_grant,
                     bar_if.bmbif_piu_snb1_grant, bar_if.bmbif_piu_snb0_grant};
  assign w_accept = bar_if.piu_bar_vld & (r_state == ST_IDLE);

  // Next-state, pending-mask, payload and watchdog computation.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_bus_nxt   = r_bus;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_bus_nxt  = bar_if.piu_bar_req_bus;
          w_pend_nxt = bar_if.piu_bar_tgt;
          if (bar_if.piu_bar_tgt != 4'b0000) begin
            w_state_nxt = ST_REQ;
            // Counter already reads 1 during the first request cycle, so the
            // registered flag lines up with the TMO_CYC-th request cycle.
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Grants for targets no longer pending are simply masked off.
        w_pend_nxt = r_pend & ~w_grant;
        if (r_cnt == TMO_VAL) begin
          w_cnt_nxt = r_cnt;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        w_tmo_nxt = r_tmo | (w_cnt_nxt == TMO_VAL);
        if (w_pend_nxt == 4'b0000) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_tmo_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pend_nxt  = 4'b0000;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_tmo_nxt   = 1'b0;
      end
    endcase
  end

  // State, pending mask, payload and watchdog registers.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_state <= ST_IDLE;
      r_pend  <= 4'b0000;
      r_bus   <= {BUS_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_bus   <= w_bus_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Pending bits are zero outside the request phase, so they drive the
  // requests directly.
  assign bar_if.piu_bmbif_snb0_req = r_pend[0];
  assign bar_if.piu_bmbif_snb1_req = r_pend[1];
  assign bar_if.piu_bmbif_ncq_req  = r_pend[2];
  assign bar_if.piu_bmbif_ctcq_req = r_pend[3];
  assign bar_if.piu_bmbif_req_bus  = r_bus;
  assign bar_if.piu_bar_rdy        = (r_state == ST_IDLE);
  assign bar_if.piu_bar_done       = (r_state == ST_DONE);
  assign bar_if.piu_bar_tmo        = r_tmo;

endmodule
